apb_mem_slave: RTL and testbench

//  APB completer consuming the bridge's PSELx/PENABLE/PADDR/PWRITE/PWDATA; one instance per PSEL line.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_slave_mem_array.sv | 31 +++
 rtl/apb_mem_slave.sv | 134 +++++++++++++
 tb/tb_apb_mem_slave.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width defaults, wait-counter width and the one-hot
// state encodings used by both the bridge and its completers.
package apb_pkg;

   localparam int APB_DATAWIDTH = 8;
   localparam int APB_ADDRWIDTH = 8;
   localparam int WAIT_CNT_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b001,
      ST_SETUP  = 3'b010,
      ST_ACCESS = 3'b100
   } apb_state_e;

endpackage

// File: rtl/apb_slave_mem_array.sv
// Register-array storage for the APB memory completer: async clear,
// one synchronous write port and one combinational read port.
module apb_slave_mem_array #(
   parameter int DATAWIDTH = 8,
   parameter int DEPTH     = 64,
   parameter int IDXW      = 6
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 we,
   input  logic [IDXW-1:0]      waddr,
   input  logic [DATAWIDTH-1:0] wdata,
   input  logic [IDXW-1:0]      raddr,
   output logic [DATAWIDTH-1:0] rdata
);

   logic [DATAWIDTH-1:0] mem [DEPTH];

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer with a DEPTH x DATAWIDTH memory and WAIT_CYCLES wait states.
// Optional APB_SLV_ERR_EN: out-of-range addresses raise PSLVERR instead of aliasing.
module apb_mem_slave
   import apb_pkg::*;
#(
   parameter int DATAWIDTH   = APB_DATAWIDTH,
   parameter int ADDRWIDTH   = APB_ADDRWIDTH,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic                 PWRITE,
   input  logic [ADDRWIDTH:0]   PADDR,
   input  logic [DATAWIDTH-1:0] PWDATA,
   output logic [DATAWIDTH-1:0] PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR
);

   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

   apb_state_e            state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDRWIDTH-1:0]  addr_q;
   logic                  write_q;
   logic [DATAWIDTH-1:0]  wdata_q;
   logic [DATAWIDTH-1:0]  prdata_q;
   logic [DATAWIDTH-1:0]  mem_rdata;
   logic [IDXW-1:0]       idx_q, idx_in;
   logic                  setup_req, access_req;
   logic                  capture, mem_we;
   logic                  err_q, err_in;
   logic                  unused_bits;

   assign setup_req  = PSEL & ~PENABLE;
   assign access_req = PSEL & PENABLE;
   assign idx_q      = addr_q[IDXW-1:0];
   assign idx_in     = PADDR[IDXW-1:0];

`ifdef APB_SLV_ERR_EN
   assign err_q       = 32'(addr_q) >= 32'(DEPTH);
   assign err_in      = 32'(PADDR[ADDRWIDTH-1:0]) >= 32'(DEPTH);
   assign unused_bits = PADDR[ADDRWIDTH];
`else
   assign err_q       = 1'b0;
   assign err_in      = 1'b0;
   assign unused_bits = ^{PADDR[ADDRWIDTH], addr_q};
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A SETUP phase seen in ACCESS restarts the transfer; PSEL dropping aborts it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (setup_req) begin
               capture = 1'b1;
               cnt_d   = WAIT_LOAD;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!PSEL) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (!PENABLE) begin
               capture = 1'b1;
               cnt_d   = WAIT_LOAD;
            end else if (cnt_q == '0) begin
               mem_we  = write_q & ~err_q;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read data is fetched at SETUP so it is stable for the whole access phase.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         prdata_q <= '0;
      end else if (capture) begin
         addr_q  <= PADDR[ADDRWIDTH-1:0];
         write_q <= PWRITE;
         wdata_q <= PWDATA;
         if (!PWRITE) begin
            prdata_q <= err_in ? '0 : mem_rdata;
         end
      end
   end

   assign PREADY  = (state_q == ST_ACCESS) & (cnt_q == '0) & access_req;
   assign PSLVERR = PREADY & err_q;
   assign PRDATA  = prdata_q;

   apb_slave_mem_array #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (DEPTH),
      .IDXW      (IDXW)
   ) u_mem (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .we      (mem_we),
      .waddr   (idx_q),
      .wdata   (wdata_q),
      .raddr   (idx_in),
      .rdata   (mem_rdata)
   );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: three instances with WAIT_CYCLES 1, 0 and 3
// share clock and reset; expected results flow through a scoreboard queue.
module tb_apb_mem_slave;

   typedef struct {
      logic       is_read;
      logic [7:0] data;
      logic       err;
      int         acc;
   } exp_t;

   logic       pclk;
   logic       presetn;
   logic       psel    [3];
   logic       penable [3];
   logic       pwrite  [3];
   logic [8:0] paddr   [3];
   logic [7:0] pwdata  [3];
   logic [7:0] prdata  [3];
   logic       pready  [3];
   logic       pslverr [3];

   int   total;
   int   bad;
   exp_t sb[$];

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      apb_mem_slave #(
         .DATAWIDTH   (8),
         .ADDRWIDTH   (8),
         .DEPTH       (64),
         .WAIT_CYCLES ((g == 0) ? 1 : (g == 1) ? 0 : 3)
      ) u_dut (
         .PCLK    (pclk),
         .PRESETn (presetn),
         .PSEL    (psel[g]),
         .PENABLE (penable[g]),
         .PWRITE  (pwrite[g]),
         .PADDR   (paddr[g]),
         .PWDATA  (pwdata[g]),
         .PRDATA  (prdata[g]),
         .PREADY  (pready[g]),
         .PSLVERR (pslverr[g])
      );
   end

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Called at 1 time unit after a rising edge; returns at the same phase after completion.
   task automatic apb_xfer(input int d, input logic wr, input logic [8:0] addr,
                           input logic [7:0] wd, output int acc, output logic [7:0] rd,
                           output logic err, output logic leak);
      logic done;
      acc  = 0;
      rd   = '0;
      err  = 1'b0;
      leak = 1'b0;
      done = 1'b0;
      psel[d]    = 1'b1;
      penable[d] = 1'b0;
      pwrite[d]  = wr;
      paddr[d]   = addr;
      pwdata[d]  = wd;
      @(posedge pclk); #1;
      penable[d] = 1'b1;
      paddr[d]   = addr ^ 9'h00F;
      pwdata[d]  = ~wd;
      for (int i = 0; i < 32 && !done; i++) begin
         @(negedge pclk);
         acc++;
         if (pready[d] === 1'b1) begin
            rd   = prdata[d];
            err  = pslverr[d];
            done = 1'b1;
         end else if (pslverr[d] !== 1'b0) begin
            leak = 1'b1;
         end
         @(posedge pclk); #1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("[TB] FAIL timeout dut=%0d addr=%h got=no PREADY exp=PREADY within 32 cycles", d, addr);
         psel[d]    = 1'b0;
         penable[d] = 1'b0;
      end
   endtask

   task automatic bus_idle(input int d, input int n);
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
      repeat (n) begin
         @(posedge pclk); #1;
      end
   endtask

   task automatic test_reset;
      presetn = 1'b0;
      for (int d = 0; d < 3; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
         paddr[d] = '0; pwdata[d] = '0;
      end
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      for (int d = 0; d < 3; d++) begin
         total++;
         if ({pready[d], pslverr[d], prdata[d]} !== 10'h000) begin
            bad++;
            $display("[TB] FAIL reset_outputs dut=%0d got=%b/%b/%h exp=0/0/00", d, pready[d], pslverr[d], prdata[d]);
         end
      end
      @(posedge pclk); #1;
      presetn = 1'b1;
      @(posedge pclk); #1;
   endtask

   task automatic test_write_read;
      int acc; logic [7:0] rd; logic err, leak; exp_t e;
      sb.push_back('{is_read: 1'b0, data: 8'h00, err: 1'b0, acc: 2});
      sb.push_back('{is_read: 1'b1, data: 8'h5A, err: 1'b0, acc: 2});
      apb_xfer(0, 1'b1, 9'h003, 8'h5A, acc, rd, err, leak);
      bus_idle(0, 1);
      for (int k = 0; k < 2; k++) begin
         if (k == 1) apb_xfer(0, 1'b0, 9'h003, 8'h00, acc, rd, err, leak);
         e = sb.pop_front();
         total++;
         if (acc !== e.acc || err !== e.err || leak !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wr_rd_timing k=%0d got=acc%0d err%b leak%b exp=acc%0d err%b leak0", k, acc, err, leak, e.acc, e.err);
         end
         if (e.is_read) begin
            total++;
            if (rd !== e.data) begin
               bad++;
               $display("[TB] FAIL wr_rd_data got=%h exp=%h", rd, e.data);
            end
         end
      end
      apb_xfer(0, 1'b1, 9'h003, 8'h11, acc, rd, err, leak);
      bus_idle(0, 2);
      total++;
      if (prdata[0] !== 8'h5A) begin
         bad++;
         $display("[TB] FAIL prdata_hold got=%h exp=5a", prdata[0]);
      end
   endtask

   task automatic test_back_to_back;
      int acc; logic [7:0] rd; logic err, leak; exp_t e;
      for (int i = 0; i < 8; i++) begin
         logic wr;
         wr = (i < 4);
         sb.push_back('{is_read: ~wr, data: 8'(i % 4 + 1), err: 1'b0, acc: 1});
         apb_xfer(1, wr, 9'(i % 4), 8'(i % 4 + 1), acc, rd, err, leak);
         e = sb.pop_front();
         total++;
         if (acc !== e.acc || err !== e.err) begin
            bad++;
            $display("[TB] FAIL b2b_timing i=%0d got=acc%0d err%b exp=acc%0d err%b", i, acc, err, e.acc, e.err);
         end
         if (e.is_read) begin
            total++;
            if (rd !== e.data) begin
               bad++;
               $display("[TB] FAIL b2b_data i=%0d got=%h exp=%h", i, rd, e.data);
            end
         end
      end
      bus_idle(1, 1);
   endtask

   task automatic test_addr_alias;
      int acc; logic [7:0] rd; logic err, leak; exp_t e;
      logic [8:0] rd_addr [2];
`ifdef APB_SLV_ERR_EN
      sb.push_back('{is_read: 1'b0, data: 8'h00, err: 1'b1, acc: 2});
      sb.push_back('{is_read: 1'b1, data: 8'h00, err: 1'b1, acc: 2});
      sb.push_back('{is_read: 1'b1, data: 8'h00, err: 1'b0, acc: 2});
      rd_addr[0] = 9'h050; rd_addr[1] = 9'h010;
`else
      sb.push_back('{is_read: 1'b0, data: 8'h00, err: 1'b0, acc: 2});
      sb.push_back('{is_read: 1'b1, data: 8'hFF, err: 1'b0, acc: 2});
      sb.push_back('{is_read: 1'b1, data: 8'hFF, err: 1'b0, acc: 2});
      rd_addr[0] = 9'h010; rd_addr[1] = 9'h050;
`endif
      for (int k = 0; k < 3; k++) begin
         if (k == 0) apb_xfer(0, 1'b1, 9'h050, 8'hFF, acc, rd, err, leak);
         else        apb_xfer(0, 1'b0, rd_addr[k-1], 8'h00, acc, rd, err, leak);
         e = sb.pop_front();
         total++;
         if (acc !== e.acc || err !== e.err || leak !== 1'b0 || (e.is_read && rd !== e.data)) begin
            bad++;
            $display("[TB] FAIL alias_err k=%0d got=acc%0d err%b leak%b rd%h exp=acc%0d err%b leak0 rd%h",
                     k, acc, err, leak, rd, e.acc, e.err, e.data);
         end
      end
      bus_idle(0, 1);
   endtask

   task automatic test_abort;
      int acc; logic [7:0] rd; logic err, leak; exp_t e;
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
      paddr[0] = 9'h005; pwdata[0] = 8'h77;
      @(posedge pclk); #1;
      penable[0] = 1'b1;
      @(negedge pclk);
      total++;
      if (pready[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_wait got=%b exp=0", pready[0]);
      end
      @(posedge pclk); #1;
      bus_idle(0, 2);
      sb.push_back('{is_read: 1'b1, data: 8'h00, err: 1'b0, acc: 2});
      apb_xfer(0, 1'b0, 9'h005, 8'h00, acc, rd, err, leak);
      e = sb.pop_front();
      total++;
      if (rd !== e.data || acc !== e.acc) begin
         bad++;
         $display("[TB] FAIL abort_read got=%h acc%0d exp=%h acc%0d", rd, acc, e.data, e.acc);
      end
      bus_idle(0, 1);
   endtask

   task automatic test_wait3_resetup;
      int acc; logic [7:0] rd; logic err, leak; exp_t e;
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
      paddr[2] = 9'h009; pwdata[2] = 8'h44;
      @(posedge pclk); #1;
      penable[2] = 1'b1;
      @(posedge pclk); #1;
      sb.push_back('{is_read: 1'b0, data: 8'h00, err: 1'b0, acc: 4});
      sb.push_back('{is_read: 1'b1, data: 8'h00, err: 1'b0, acc: 4});
      sb.push_back('{is_read: 1'b1, data: 8'h55, err: 1'b0, acc: 4});
      for (int k = 0; k < 3; k++) begin
         if (k == 0)      apb_xfer(2, 1'b1, 9'h00A, 8'h55, acc, rd, err, leak);
         else if (k == 1) apb_xfer(2, 1'b0, 9'h009, 8'h00, acc, rd, err, leak);
         else             apb_xfer(2, 1'b0, 9'h00A, 8'h00, acc, rd, err, leak);
         e = sb.pop_front();
         total++;
         if (acc !== e.acc || err !== e.err || leak !== 1'b0 || (e.is_read && rd !== e.data)) begin
            bad++;
            $display("[TB] FAIL wait3 k=%0d got=acc%0d err%b rd%h exp=acc%0d err%b rd%h",
                     k, acc, err, rd, e.acc, e.err, e.data);
         end
      end
      bus_idle(2, 1);
   endtask

   task automatic test_reset_mid;
      int acc; logic [7:0] rd; logic err, leak; exp_t e;
      apb_xfer(0, 1'b0, 9'h003, 8'h00, acc, rd, err, leak);
      total++;
      if (rd !== 8'h11) begin
         bad++;
         $display("[TB] FAIL pre_reset_read got=%h exp=11", rd);
      end
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
      paddr[0] = 9'h007; pwdata[0] = 8'h33;
      @(posedge pclk); #1;
      penable[0] = 1'b1;
      @(posedge pclk); #2;
      presetn = 1'b0;
      #1;
      total++;
      if ({pready[0], pslverr[0], prdata[0]} !== 10'h000) begin
         bad++;
         $display("[TB] FAIL reset_mid got=%b/%b/%h exp=0/0/00", pready[0], pslverr[0], prdata[0]);
      end
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(posedge pclk); #1;
      presetn = 1'b1;
      @(posedge pclk); #1;
      sb.push_back('{is_read: 1'b1, data: 8'h00, err: 1'b0, acc: 2});
      apb_xfer(0, 1'b0, 9'h007, 8'h00, acc, rd, err, leak);
      e = sb.pop_front();
      total++;
      if (rd !== e.data || acc !== e.acc) begin
         bad++;
         $display("[TB] FAIL reset_read got=%h acc%0d exp=%h acc%0d", rd, acc, e.data, e.acc);
      end
      bus_idle(0, 1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_addr_alias();
      test_abort();
      test_wait3_resetup();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
